prf_wr_bank_arbiter: RTL
========================

// Module: prf_wr_bank_arbiter
// PURPOSE
//   Shares the 4 single-write-port PRF banks between the PRF_WR_COUNT writeback requesters.
//   Each requester has a 1-entry holding buffer. Per bank, a round-robin arbiter grants 1 write/cycle.
//   Bank select = PR[LOG_PRF_BANK_COUNT-1:0].
//   Sits between the FU writeback stage and the PRF bank arrays. Drives the per-bank write and wakeup broadcast.
// PARAMETERS
//   PRF_WR_COUNT    7    number of writeback requesters (from core_types_pkg)
//   PRF_BANK_COUNT  4    number of PRF banks, power of 2 (from core_types_pkg)
//   PR_COUNT        128  physical registers; LOG_PR_COUNT=7 (from core_types_pkg)
//   XLEN            32   data width (from core_types_pkg)
// PORTS
//   CLK                 in   1                        core clock
//   nRST                in   1                        asynchronous active-low reset
//   wr_valid_by_req     in   PRF_WR_COUNT             requester i presents a write
//   wr_PR_by_req        in   PRF_WR_COUNT x LOG_PR_COUNT   destination physical register
//   wr_data_by_req      in   PRF_WR_COUNT x XLEN      write data
//   wr_ready_by_req     out  PRF_WR_COUNT             requester i may transfer this cycle
//   bank_wen_by_bank    out  PRF_BANK_COUNT           bank b writes this cycle
//   bank_waddr_by_bank  out  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  PR[6:2]
//   bank_wdata_by_bank  out  PRF_BANK_COUNT x XLEN    write data
//   bank_wPR_by_bank    out  PRF_BANK_COUNT x LOG_PR_COUNT  full PR, for IQ/ROB wakeup
// BEHAVIOUR
//   - Transfer: wr_valid & wr_ready at a rising edge loads buf[i] = {PR, data}.
//   - A requester with valid & !ready holds PR/data stable.
//   - wr_ready_by_req[i] = !buf_valid[i] | grant[i]. It is combinational from registered state only; it never depends on wr_valid.
//   - Arbitration is combinational from the buffers. Candidate set for bank b = {i : buf_valid[i] & buf_PR[i][1:0]==b}.
//   - The granted candidate is the lowest index i with i >= rr_ptr[b], cyclically wrapping to 0.
//   - bank_* outputs are combinational from the granted buffer. Bank outputs are 0 when there is no candidate.
//   - Latency: a request transferred at edge N is written at edge N+1 at the earliest. Throughput is 1 write/requester/cycle.
//   - On grant of i for bank b: rr_ptr[b] <= (i+1) mod PRF_WR_COUNT. If b has no grant, rr_ptr[b] is unchanged.
//   - Simultaneous grant and new transfer on requester i: buf[i] is overwritten with the new request and stays valid.
//   - Grant with no new transfer clears buf_valid[i].
//   - Different banks never interact. Up to 4 grants/cycle; at most 1 per bank; a requester is in at most 1 bank set.
//   - Starvation bound: a buffered request is granted within PRF_WR_COUNT cycles.
//   - Reset (async, any time): buf_valid=0 and rr_ptr=0 for all banks. In-flight buffered writes are discarded.
//   - Reset output values: wr_ready_by_req=all 1s; bank_wen/waddr/wdata/wPR = 0.
//   - No state machine beyond the per-requester buffer-valid flag (EMPTY/FULL) and the per-bank pointer.
// CONFIGURATION
//   PRF_WR_ARB_PERF_EN defined:
//     - Adds output conflict_cnt_by_bank (PRF_BANK_COUNT x 16).
//     - Per bank, +1 each cycle the candidate count is >1. Saturates at 16'hFFFF. Reset to 0.
//   PRF_WR_ARB_PERF_EN undefined: the port and counters are absent; all other behaviour is identical.
// STRUCTURE
//   core_types_pkg additions:
//     - typedef logic [LOG_PR_COUNT-1:0] pr_t
//     - typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t
//     - typedef struct packed {pr_t PR; logic [XLEN-1:0] data;} prf_wr_req_t
//   Sub-module prf_wr_rr_arb:
//     - Parameter N (default PRF_WR_COUNT).
//     - Inputs req[N] and ptr; output one-hot gnt[N]. Purely combinational.
//     - Instantiated once per bank. The pointer register lives in the parent.
// TESTING
//   1. Reset: hold nRST=0 with random inputs -> all wr_ready=1, all bank_wen=0. After release, the first writes are granted from ptr 0.
//   2. Single write: req 3, PR=7'h25, data=32'hDEADBEEF at cycle 0 -> cycle 1: bank_wen=4'b0010, waddr=5'h09, wPR=7'h25.
//   3. Bank conflict: reqs 0,2,5 write PRs 4, 8, 12 (all bank 0) at cycle 0.
//      -> bank 0 grants 0, 2, 5 on cycles 1, 2, 3 (ptr 0).
//      -> wr_ready is 0 for stalled requesters until granted.
//   4. No conflict: reqs 0-3 target PRs 0, 1, 2, 3 -> cycle 1: bank_wen=4'b1111. Back-to-back every cycle with no stalls.
//   5. Fairness/wrap:
//      - Reqs 6 and 0 continuously target bank 1 -> grants alternate 6, 0, 6, 0.
//      - ptr wraps 0 after granting 6.
//      - No request waits more than 7 cycles.
//   6. Mid-operation reset: assert nRST while 3 buffers are full -> next cycle: no bank_wen, buffers empty, ptrs 0.
//      With PRF_WR_ARB_PERF_EN: counters are 0; test 3 yields conflict_cnt[0]=2.

Source files
------------

// File: rtl/prf_wr_bank_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prf_wr_bank_arbiter_pkg
// Brief    : Shared sizes, types and helpers for the PRF write-bank arbiter.
//            Optional build macro used by the top: PRF_WR_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
package prf_wr_bank_arbiter_pkg;

  // Core sizing
  localparam int PRF_WR_COUNT       = 7;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int PR_COUNT           = 128;
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int XLEN               = 32;

  // Row address inside one bank: the PR bits above the bank select
  localparam int BANK_ADDR_W        = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  // Width of a per-bank round-robin pointer over the requesters
  localparam int RR_PTR_W           = $clog2(PRF_WR_COUNT);

  // Per-requester holding buffer occupancy encoding
  localparam logic [0:0] c_BUF_EMPTY = 1'b0;
  localparam logic [0:0] c_BUF_FULL  = 1'b1;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;

  typedef struct packed {
    pr_t             PR;
    logic [XLEN-1:0] data;
  } prf_wr_req_t;

  // Pointer value that puts requester idx last in line for the next round
  function automatic logic [RR_PTR_W-1:0] rr_next_ptr(input int idx);
    return RR_PTR_W'((idx + 1) % PRF_WR_COUNT);
  endfunction

endpackage : prf_wr_bank_arbiter_pkg
`default_nettype wire

// File: rtl/prf_wr_bank_arbiter_rr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prf_wr_rr_arb
// Brief    : Combinational round-robin picker. Grants the lowest requesting
//            index at or above ptr, wrapping cyclically to 0. One-hot output.
// Revision : 1.0 - initial release
// ============================================================================
module prf_wr_rr_arb
  import prf_wr_bank_arbiter_pkg::*;
#(
  parameter int N = PRF_WR_COUNT
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  // Scan from ptr upward, wrapping, and keep only the first requester found
  always_comb begin
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      int w_idx;
      w_idx = (int'(ptr) + k) % N;
      if ((gnt == '0) && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule : prf_wr_rr_arb
`default_nettype wire

// File: rtl/prf_wr_bank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prf_wr_bank_arbiter
// Brief    : Shares the single-write-port PRF banks between the writeback
//            requesters. Each requester owns a 1-entry holding buffer; each
//            bank picks one buffered write per cycle round-robin and drives
//            the bank write plus the wakeup PR broadcast.
//            Build macro PRF_WR_ARB_PERF_EN adds per-bank conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module prf_wr_bank_arbiter
  import prf_wr_bank_arbiter_pkg::*;
(
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic [PRF_WR_COUNT-1:0]                       wr_valid_by_req,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]     wr_PR_by_req,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]             wr_data_by_req,
  output logic [PRF_WR_COUNT-1:0]                       wr_ready_by_req,
  output logic [PRF_BANK_COUNT-1:0]                     bank_wen_by_bank,
  output logic [PRF_BANK_COUNT-1:0][BANK_ADDR_W-1:0]    bank_waddr_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]           bank_wdata_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   bank_wPR_by_bank
`ifdef PRF_WR_ARB_PERF_EN
  ,
  output logic [PRF_BANK_COUNT-1:0][15:0]               conflict_cnt_by_bank
`endif
);

  // Holding buffers and per-bank round-robin pointers
  logic [PRF_WR_COUNT-1:0]                     r_buf_valid;
  prf_wr_req_t                                 r_buf_req [PRF_WR_COUNT];
  logic [RR_PTR_W-1:0]                         r_rr_ptr  [PRF_BANK_COUNT];

  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_cand_by_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_gnt_by_bank;
  logic [PRF_WR_COUNT-1:0]                     w_grant;
  logic [PRF_WR_COUNT-1:0]                     w_xfer;
  logic [RR_PTR_W-1:0]                         w_ptr_next [PRF_BANK_COUNT];

  // Sort every full buffer into the candidate set of the bank its PR selects
  always_comb begin
    w_cand_by_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        w_cand_by_bank[b][i] = r_buf_valid[i] &&
          (r_buf_req[i].PR[LOG_PRF_BANK_COUNT-1:0] == prf_bank_t'(b));
      end
    end
  end

  // One independent round-robin picker per bank
  generate
    for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
      prf_wr_rr_arb #(
        .N   (PRF_WR_COUNT)
      ) u_arb (
        .req (w_cand_by_bank[gb]),
        .ptr (r_rr_ptr[gb]),
        .gnt (w_gnt_by_bank[gb])
      );
    end
  endgenerate

  // A requester sits in exactly one bank set, so OR-ing the banks is safe
  always_comb begin
    w_grant = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_grant = w_grant | w_gnt_by_bank[b];
    end
  end

  // Ready looks only at registered state so it never loops back through wr_valid
  assign wr_ready_by_req = ~r_buf_valid | w_grant;
  assign w_xfer          = wr_valid_by_req & wr_ready_by_req;

  // Steer the granted buffer onto each bank port and work out the next pointer
  always_comb begin
    bank_wen_by_bank   = '0;
    bank_waddr_by_bank = '0;
    bank_wdata_by_bank = '0;
    bank_wPR_by_bank   = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_ptr_next[b]       = r_rr_ptr[b];
      bank_wen_by_bank[b] = |w_gnt_by_bank[b];
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (w_gnt_by_bank[b][i]) begin
          bank_waddr_by_bank[b] = r_buf_req[i].PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          bank_wdata_by_bank[b] = r_buf_req[i].data;
          bank_wPR_by_bank[b]   = r_buf_req[i].PR;
          w_ptr_next[b]         = rr_next_ptr(i);
        end
      end
    end
  end

  // Buffer fill/drain: a new transfer wins over a same-cycle grant drain
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        r_buf_valid[i] <= c_BUF_EMPTY;
        r_buf_req[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (w_xfer[i]) begin
          r_buf_valid[i] <= c_BUF_FULL;
          r_buf_req[i]   <= '{PR: wr_PR_by_req[i], data: wr_data_by_req[i]};
        end else if (w_grant[i]) begin
          r_buf_valid[i] <= c_BUF_EMPTY;
        end
      end
    end
  end

  // Advance a bank's pointer only when that bank actually wrote
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        r_rr_ptr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (bank_wen_by_bank[b]) begin
          r_rr_ptr[b] <= w_ptr_next[b];
        end
      end
    end
  end

`ifdef PRF_WR_ARB_PERF_EN
  logic [PRF_BANK_COUNT-1:0][15:0] r_conflict_cnt;
  logic [PRF_BANK_COUNT-1:0]       w_conflict;

  // A bank is conflicted when more than one buffer wants it this cycle
  always_comb begin
    w_conflict = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_conflict[b] = ($countones(w_cand_by_bank[b]) > 1);
    end
  end

  // Saturating per-bank conflict counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_conflict_cnt <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_conflict[b] && (r_conflict_cnt[b] != 16'hFFFF)) begin
          r_conflict_cnt[b] <= r_conflict_cnt[b] + 16'd1;
        end
      end
    end
  end

  assign conflict_cnt_by_bank = r_conflict_cnt;
`endif

endmodule : prf_wr_bank_arbiter
`default_nettype wire
